// File: rtl/inst_fetch.sv
// Instruction fetch unit: drives the PC to a combinational imem and registers the
// returned word behind a valid/ready handshake, with redirect, halt-on-EBREAK and a fetch counter.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'h0010_0073,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_misalign,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_misalign_q, out_misalign_d;
  logic        misalign_pend_q, misalign_pend_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        cap;
  logic        is_halt;
  logic        accept;

  assign cap     = (state_q == StRun) & fetch_en & ~redirect_valid & (~out_valid_q | out_ready);
  assign is_halt = (imem_instr == HALT_INSTR);
  assign accept  = out_valid_q & out_ready;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    out_valid_d     = out_valid_q;
    out_pc_d        = out_pc_q;
    out_instr_d     = out_instr_q;
    out_misalign_d  = out_misalign_q;
    misalign_pend_d = misalign_pend_q;
    // A handshake completing alongside a redirect still counts.
    fetch_count_d   = fetch_count_q + {31'd0, accept};

    if (redirect_valid) begin
      pc_d            = {redirect_pc[31:2], 2'b00};
      misalign_pend_d = |redirect_pc[1:0];
      out_valid_d     = 1'b0;
      out_instr_d     = NOP_INSTR;
      state_d         = fetch_en ? StRun : StIdle;
    end else begin
      if (cap) begin
        out_valid_d     = 1'b1;
        out_pc_d        = pc_q;
        out_instr_d     = imem_instr;
        out_misalign_d  = misalign_pend_q;
        misalign_pend_d = 1'b0;
        pc_d            = is_halt ? pc_q : pc_q + 32'd4;
      end else if (accept) begin
        out_valid_d = 1'b0;
        out_instr_d = NOP_INSTR;
      end

      unique case (state_q)
        StIdle: if (fetch_en) state_d = StRun;
        StRun: begin
          if (!fetch_en)          state_d = StIdle;
          else if (cap && is_halt) state_d = StHalt;
        end
        StHalt:  state_d = StHalt;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      pc_q            <= {RESET_PC[31:2], 2'b00};
      out_valid_q     <= 1'b0;
      out_pc_q        <= 32'd0;
      out_instr_q     <= NOP_INSTR;
      out_misalign_q  <= 1'b0;
      misalign_pend_q <= 1'b0;
      fetch_count_q   <= 32'd0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      out_valid_q     <= out_valid_d;
      out_pc_q        <= out_pc_d;
      out_instr_q     <= out_instr_d;
      out_misalign_q  <= out_misalign_d;
      misalign_pend_q <= misalign_pend_d;
      fetch_count_q   <= fetch_count_d;
    end
  end

  // pc_q is kept word-aligned, so it maps straight onto the imem address.
  assign imem_addr    = pc_q;
  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_instr    = out_instr_q;
  assign out_misalign = out_misalign_q;
  assign halted       = (state_q == StHalt);
  assign fetch_count  = fetch_count_q;

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch unit that initiates reads into the combinational instruction memory (imem) and presents fetched words to decode. It holds the program counter and drives a word address to imem every cycle. It captures the returned instruction into an output register with a valid/ready handshake. It handles redirects (branch/jump targets), stalls from decode, halt on EBREAK, and counts accepted instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
HALT_INSTR, 32'h0010_0073, encoding (EBREAK) that stops fetching once captured.
NOP_INSTR, 32'h0000_0013, value driven on out_instr whenever out_valid=0.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
fetch_en  in  1  level enable; fetching is permitted while high.
imem_addr  out  32  byte address to imem; always equal to pc_q, with bits [1:0]=00.
imem_instr  in  32  instruction returned combinationally by imem for imem_addr.
redirect_valid  in  1  single-cycle pulse that loads a new PC and flushes the output.
redirect_pc  in  32  redirect target.
out_valid  out  1  output register holds a valid instruction.
out_ready  in  1  decode accepts the instruction this cycle.
out_pc  out  32  PC of out_instr.
out_instr  out  32  fetched instruction.
out_misalign  out  1  instruction was fetched from a redirect target with nonzero bits [1:0].
halted  out  1  FSM is in HALT.
fetch_count  out  32  count of accepted handshakes (out_valid & out_ready).

Behaviour:
- Reset (async assert, sync release): pc_q=RESET_PC, state=IDLE, out_valid=0, out_pc=0, out_instr=NOP_INSTR, out_misalign=0, halted=0, fetch_count=0, misalign_pend=0.
- imem_addr = {pc_q[31:2],2'b00}, combinational from pc_q. imem is combinational, so capture happens in the same cycle as the address is presented: 1-cycle fetch latency and 1 instruction/cycle peak throughput.
- FSM states: IDLE, RUN, HALT.
  - IDLE -> RUN when fetch_en=1.
  - RUN -> IDLE when fetch_en=0. No capture occurs in that cycle; an already-valid output is kept until accepted.
  - RUN -> HALT on the cycle a word equal to HALT_INSTR is captured. The halt word itself is presented with out_valid=1. pc_q is not advanced past it.
  - HALT leaves only on redirect or reset: to RUN if fetch_en=1, else IDLE.
- Capture enable: cap = (state==RUN) & fetch_en & ~redirect_valid & (~out_valid | out_ready).
- On cap:
  - out_valid<=1, out_pc<=pc_q, out_instr<=imem_instr, out_misalign<=misalign_pend.
  - misalign_pend<=0.
  - pc_q<=pc_q+4, mod 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000. pc_q is not advanced if the word is HALT_INSTR.
- Without cap, if out_valid & out_ready: out_valid<=0 and out_instr<=NOP_INSTR.
- While out_valid=1 and out_ready=0, out_pc, out_instr and out_misalign stay stable.
- Redirect has the highest priority in any state:
  - pc_q<={redirect_pc[31:2],2'b00}; misalign_pend<=|redirect_pc[1:0].
  - out_valid<=0 and out_instr<=NOP_INSTR (flush); no capture in that cycle.
  - HALT exits as described above.
  - A handshake that completes in the same cycle as a redirect still counts as accepted.
- fetch_count increments by 1 on every out_valid & out_ready cycle, including a redirect cycle. It wraps from 0xFFFF_FFFF to 0.
- halted = (state==HALT), registered.
- Reset asserted mid-stream immediately clears all state to reset values. No partial capture occurs.

Test Plan:
- Reset release, fetch_en=1, out_ready=1, imem holds {0x00500093, 0x00600113, 0x002081b3, 0x00000013} at 0/4/8/C -> out_valid rises the cycle after fetch_en. Consecutive outputs are (pc,instr) = (0,00500093), (4,00600113), (8,002081b3), (C,00000013). fetch_count=4.
- Hold out_ready=0 for 3 cycles after first capture -> out_pc=0 and out_instr=00500093 stay stable. imem_addr stays at 0x4. After release, the sequence continues with no loss or duplication.
- Redirect to 0x0000_0005 while out_valid=1 -> out_valid=0 next cycle. imem_addr=0x4. The next output is (4,00600113) with out_misalign=1; the following output has out_misalign=0.
- imem word at 0x10 = 0x00100073 -> captured with out_valid=1 and halted=1. imem_addr stays 0x10 and no further captures occur. Redirect to 0x0 -> halted=0 and fetch restarts at 00500093.
- Redirect to 0xFFFF_FFFC, run 2 fetches -> out_pc=FFFF_FFFC then 0000_0000.
- Assert rst_n=0 asynchronously mid-stream -> out_valid=0, out_instr=00000013 and fetch_count=0 immediately. imem_addr=RESET_PC.
